mul_arbiter: RTL and testbench

MUL_ARBITER -- requirements
Module: mul_arbiter

---
 rtl/mul_arbiter.sv | 112 +++++++++++
 tb/tb_mul_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_arbiter.sv
// Two-requester round-robin front end for one shared 8x8 unsigned array multiplier.
// A transaction runs IDLE (arbitrate) -> CALC (grant) -> RESP (done).

module mul8x8_array (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  logic [15:0] pp  [8];
  logic [15:0] acc [9];

  assign acc[0] = 16'h0000;

  // Shifted partial-product rows summed down the array.
  for (genvar gi = 0; gi < 8; gi++) begin : g_row
    assign pp[gi]      = b[gi] ? ({8'h00, a} << gi) : 16'h0000;
    assign acc[gi + 1] = acc[gi] + pp[gi];
  end

  assign p = acc[8];
endmodule

module mul_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [7:0]  a0,
  input  logic [7:0]  b0,
  input  logic        req1,
  input  logic [7:0]  a1,
  input  logic [7:0]  b1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [15:0] result,
  output logic        ovf,
  output logic        gid,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t      state, state_next;
  logic        ptr;
  logic        owner;
  logic        win;
  logic [7:0]  op_a, op_b;
  logic [15:0] prod;

  mul8x8_array u_mul (
    .a (op_a),
    .b (op_b),
    .p (prod)
  );

  // On a tie the requester that was not served last wins.
  assign win = (req0 && req1) ? ~ptr : req1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= 1'b1;
      owner  <= 1'b0;
      op_a   <= 8'h00;
      op_b   <= 8'h00;
      result <= 16'h0000;
      ovf    <= 1'b0;
      gid    <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && (req0 || req1)) begin
        owner <= win;
        ptr   <= win;
        op_a  <= win ? a1 : a0;
        op_b  <= win ? b1 : b0;
      end
      // gid moves together with result so it always names the result's owner.
      if (state == CALC) begin
        result <= prod;
        ovf    <= |prod[15:8];
        gid    <= owner;
      end
    end
  end

  always_comb begin
    state_next = state;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    done0      = 1'b0;
    done1      = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) state_next = CALC;
      end
      CALC: begin
        state_next = RESP;
        busy       = 1'b1;
        gnt0       = ~owner;
        gnt1       = owner;
      end
      RESP: begin
        state_next = IDLE;
        busy       = 1'b1;
        done0      = ~gid;
        done1      = gid;
      end
      default: state_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: timeline-based reference model checked every cycle,
// directed literal cases, and randomized traffic with occasional resets.

module tb_mul_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req [2];
  logic [7:0]  a   [2];
  logic [7:0]  b   [2];
  logic        gnt0, gnt1, done0, done1, ovf, gid, busy;
  logic [15:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  mul_arbiter dut (
    .clk    (clk),
    .rst    (rst),
    .req0   (req[0]),
    .a0     (a[0]),
    .b0     (b[0]),
    .req1   (req[1]),
    .a1     (a[1]),
    .b1     (b[1]),
    .gnt0   (gnt0),
    .gnt1   (gnt1),
    .done0  (done0),
    .done1  (done1),
    .result (result),
    .ovf    (ovf),
    .gid    (gid),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an operation granted at edge e shows its grant in the
  // cycle after e, its done one cycle later, and the arbiter samples again at e+3.
  logic        m_gnt0 = 0, m_gnt1 = 0, m_done0 = 0, m_done1 = 0, m_busy = 0;
  logic [15:0] m_result = 0;
  logic        m_ovf = 0, m_gid = 0, m_ptr = 1;
  int          e = 0, free_at = 0, pend_at = -1;
  logic [15:0] pend_prod = 0;
  logic        pend_owner = 0;

  initial forever begin
    @(posedge clk or posedge rst);
    m_gnt0 = 0; m_gnt1 = 0; m_done0 = 0; m_done1 = 0; m_busy = 0;
    if (rst) begin
      m_result = 0; m_ovf = 0; m_gid = 0; m_ptr = 1;
      e = 0; free_at = 0; pend_at = -1;
    end else begin
      e++;
      if (pend_at == e) begin
        m_result = pend_prod;
        m_ovf    = (pend_prod > 16'd255);
        m_gid    = pend_owner;
        if (pend_owner) m_done1 = 1; else m_done0 = 1;
        m_busy   = 1;
      end
      if (e >= free_at && (req[0] || req[1])) begin
        logic w;
        w = (req[0] && req[1]) ? !m_ptr : req[1];
        m_ptr      = w;
        pend_prod  = 16'(int'(a[w]) * int'(b[w]));
        pend_owner = w;
        pend_at    = e + 1;
        free_at    = e + 3;
        if (w) m_gnt1 = 1; else m_gnt0 = 1;
        m_busy = 1;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("cmp_gnt0",   16'(gnt0),  16'(m_gnt0));
    chk("cmp_gnt1",   16'(gnt1),  16'(m_gnt1));
    chk("cmp_done0",  16'(done0), 16'(m_done0));
    chk("cmp_done1",  16'(done1), 16'(m_done1));
    chk("cmp_busy",   16'(busy),  16'(m_busy));
    chk("cmp_result", result,     m_result);
    chk("cmp_ovf",    16'(ovf),   16'(m_ovf));
    chk("cmp_gid",    16'(gid),   16'(m_gid));
  end

  // Single isolated operation with literal expectations; block must be idle on entry.
  task automatic op(input int i, input logic [7:0] av, input logic [7:0] bv,
                    input logic [15:0] er, input logic eo);
    req[i] = 1; a[i] = av; b[i] = bv;
    @(negedge clk); #1;
    chk("op_gnt", 16'(i ? gnt1 : gnt0), 16'd1);
    chk("op_gnt_other", 16'(i ? gnt0 : gnt1), 16'd0);
    req[i] = 0; a[i] = 8'($urandom); b[i] = 8'($urandom);
    @(negedge clk); #1;
    chk("op_done", 16'(i ? done1 : done0), 16'd1);
    chk("op_result", result, er);
    chk("op_ovf", 16'(ovf), 16'(eo));
    chk("op_gid", 16'(gid), 16'(i));
    @(negedge clk); #1;
    chk("op_idle", 16'(busy), 16'd0);
    chk("op_hold", result, er);
  endtask

  initial begin
    int cyc, d0, d1;
    logic [15:0] r0, r1;
    int gid_q[$];
    int gcyc_q[$];

    req[0] = 0; req[1] = 0; a[0] = 0; b[0] = 0; a[1] = 0; b[1] = 0;
    #1 rst = 1;
    #1;
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_result", result, 16'h0000);
    chk("rst_gnt", 16'({gnt1, gnt0, done1, done0}), 16'd0);
    repeat (2) @(negedge clk);
    #1 rst = 0;

    op(0, 8'hFF, 8'hFF, 16'hFE01, 1'b1);
    op(1, 8'h0C, 8'h0A, 16'h0078, 1'b0);
    op(0, 8'h00, 8'h5A, 16'h0000, 1'b0);
    op(0, 8'h10, 8'h10, 16'h0100, 1'b1);

    // Both requests from reset, each dropped after its own grant.
    @(negedge clk); #1 rst = 1;
    req[0] = 1; a[0] = 8'h37; b[0] = 8'h05;
    req[1] = 1; a[1] = 8'h80; b[1] = 8'h02;
    @(negedge clk); #1 rst = 0;
    cyc = 0; d0 = -100; d1 = 0; r0 = 0; r1 = 0;
    gid_q.delete();
    repeat (10) begin
      @(negedge clk); #1; cyc++;
      if (gnt0) begin gid_q.push_back(0); req[0] = 0; end
      if (gnt1) begin gid_q.push_back(1); req[1] = 0; end
      if (done0) begin d0 = cyc; r0 = result; end
      if (done1) begin d1 = cyc; r1 = result; end
    end
    chk("pair_ngrants", 16'(gid_q.size()), 16'd2);
    chk("pair_first", 16'(gid_q.size() > 0 ? gid_q[0] : 9), 16'd0);
    chk("pair_second", 16'(gid_q.size() > 1 ? gid_q[1] : 9), 16'd1);
    chk("pair_done_gap", 16'(d1 - d0), 16'd3);
    chk("pair_res0", r0, 16'h0113);
    chk("pair_res1", r1, 16'h0100);

    // Both held continuously: alternation, one grant per 3 cycles.
    req[0] = 1; a[0] = 8'h03; b[0] = 8'h04;
    req[1] = 1; a[1] = 8'h05; b[1] = 8'h06;
    gid_q.delete(); gcyc_q.delete(); cyc = 0;
    repeat (12) begin
      @(negedge clk); #1; cyc++;
      if (gnt0) begin gid_q.push_back(0); gcyc_q.push_back(cyc); end
      if (gnt1) begin gid_q.push_back(1); gcyc_q.push_back(cyc); end
    end
    req[0] = 0; req[1] = 0;
    chk("rr_ngrants", 16'(gid_q.size()), 16'd4);
    for (int k = 0; k < 4; k++) begin
      chk("rr_order", 16'(gid_q.size() > k ? gid_q[k] : 9), 16'(k % 2));
      if (k > 0)
        chk("rr_spacing", 16'(gcyc_q.size() > k ? gcyc_q[k] - gcyc_q[k-1] : 0), 16'd3);
    end
    repeat (3) @(negedge clk);
    #1;

    // Reset during CALC aborts the operation.
    req[0] = 1; a[0] = 8'h07; b[0] = 8'h09;
    @(negedge clk); #1;
    chk("abort_gnt", 16'(gnt0), 16'd1);
    rst = 1;
    #1;
    chk("abort_busy", 16'(busy), 16'd0);
    chk("abort_flags", 16'({gnt1, gnt0, done1, done0, ovf, gid}), 16'd0);
    chk("abort_result", result, 16'h0000);
    @(negedge clk); #1;
    chk("abort_nodone", 16'({done1, done0}), 16'd0);
    rst = 0;
    op(0, 8'h07, 8'h09, 16'h003F, 1'b0);

    // Randomized traffic; operands may change freely once granted.
    repeat (3000) begin
      @(negedge clk); #1;
      rst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < 2; i++) begin
        logic g;
        g = i ? gnt1 : gnt0;
        if (req[i] && g) begin
          req[i] = ($urandom_range(0, 1) == 1);
          a[i] = 8'($urandom); b[i] = 8'($urandom);
        end else if (!req[i] && $urandom_range(0, 9) < 4) begin
          req[i] = 1;
          a[i] = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
          b[i] = 8'($urandom);
        end
      end
    end
    rst = 0; req[0] = 0; req[1] = 0;
    repeat (4) @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
